// File: rtl/caq_tape_player.sv
// caq_tape_player: replays a CAQ image from tape RAM as an FSK waveform.
// Optional define TAPE_MOTOR_EN: ce_tape ticks are ignored while motor is low.
module caq_tape_player #(
    parameter int ADDR_W      = 16,
    parameter int HALF0_TICKS = 4,
    parameter int HALF1_TICKS = 2,
    parameter int LEADER_BITS = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_tape,
    input  logic              loaded,
    input  logic [ADDR_W-1:0] length,
    input  logic [7:0]        data,
    input  logic              motor,
    output logic [ADDR_W-1:0] addr,
    output logic              req,
    output logic              out,
    output logic              done
);

    localparam int HMAX = (HALF0_TICKS > HALF1_TICKS) ?
                          HALF0_TICKS : HALF1_TICKS;
    localparam int CW = $clog2(HMAX + 1);
    localparam int LW = (LEADER_BITS > 1) ? $clog2(LEADER_BITS) : 1;
    localparam logic [CW-1:0] H0 = CW'(HALF0_TICKS);
    localparam logic [CW-1:0] H1 = CW'(HALF1_TICKS);
    localparam logic [LW-1:0] LLAST = LW'(LEADER_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER,
        S_FETCH,
        S_BIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [10:0]       sr_q, sr_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [LW-1:0]     lcnt_q, lcnt_d;
    logic [CW-1:0]     hcnt_q, hcnt_d;
    logic              phase_q, phase_d;
    logic              out_q, out_d;
    logic              fcnt_q, fcnt_d;
    logic              done_q, done_d;

    logic              tick;
    logic              sym;
    logic              sym_end;
    logic [CW-1:0]     hlen;
    logic [CW-1:0]     hnext;
    logic [ADDR_W-1:0] addr_inc;

`ifdef TAPE_MOTOR_EN
    assign tick = ce_tape & motor;
`else
    logic unused_motor;
    assign unused_motor = motor;
    assign tick = ce_tape;
`endif

    // phase_q=0 is the high half, phase_q=1 the low half of a symbol
    assign sym      = (state_q == S_LEADER) | sr_q[10];
    assign hlen     = sym ? H1 : H0;
    assign hnext    = hcnt_q + 1'b1;
    assign sym_end  = tick & phase_q & (hnext == hlen);
    assign addr_inc = addr_q + 1'b1;

    // next-state, counters and waveform level
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        lcnt_d  = lcnt_q;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        out_d   = out_q;
        fcnt_d  = fcnt_q;
        done_d  = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                out_d = 1'b0;
            end
            S_LEADER, S_BIT: begin
                if (tick) begin
                    out_d = ~phase_q;
                    if (hnext == hlen) begin
                        hcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        hcnt_d = hnext;
                    end
                end
                if (sym_end && state_q == S_LEADER) begin
                    lcnt_d = lcnt_q + 1'b1;
                    if (lcnt_q == LLAST) begin
                        lcnt_d  = '0;
                        fcnt_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                if (sym_end && state_q == S_BIT) begin
                    sr_d   = {sr_q[9:0], 1'b0};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 4'd10) begin
                        bcnt_d  = '0;
                        addr_d  = addr_inc;
                        fcnt_d  = 1'b0;
                        state_d = (addr_inc == len_q) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                fcnt_d = 1'b1;
                if (fcnt_q) begin
                    sr_d    = {1'b0, data, 2'b11};
                    bcnt_d  = '0;
                    hcnt_d  = '0;
                    phase_d = 1'b0;
                    fcnt_d  = 1'b0;
                    state_d = S_BIT;
                end
            end
            S_DONE: begin
                out_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (loaded) begin
            len_d   = length;
            addr_d  = '0;
            bcnt_d  = '0;
            lcnt_d  = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
            fcnt_d  = 1'b0;
            out_d   = 1'b0;
            if (length == '0)
                state_d = S_DONE;
            else if (LEADER_BITS == 0)
                state_d = S_FETCH;
            else
                state_d = S_LEADER;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            sr_q    <= '0;
            bcnt_q  <= '0;
            lcnt_q  <= '0;
            hcnt_q  <= '0;
            phase_q <= 1'b0;
            out_q   <= 1'b0;
            fcnt_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            lcnt_q  <= lcnt_d;
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    assign addr = addr_q;
    assign out  = out_q;
    assign done = done_q;
    assign req  = (state_q == S_LEADER) | (state_q == S_FETCH) |
                  (state_q == S_BIT) |
                  ((state_q == S_DONE) & (len_q != '0));

endmodule
